// File: rtl/sec_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sec_timer_ctrl : countdown timer with 1 s prescaler, pause/resume, stop   |
// | Option: SEC_TIMER_AUTORELOAD_EN enables periodic reload on expiry.        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sec_timer_ctrl #(
  parameter int unsigned DIV   = 100000000,
  parameter int unsigned SEC_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [SEC_W-1:0] load_val,
  output logic [SEC_W-1:0] remaining,
  output logic             tick,
  output logic             running,
  output logic             paused,
  output logic             done
);

  localparam int unsigned      PRE_W   = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_EXPIRE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [PRE_W-1:0] prescaler;
  logic [PRE_W-1:0] prescaler_nx;
  logic [SEC_W-1:0] remaining_nx;
  logic             wrap;

`ifdef SEC_TIMER_AUTORELOAD_EN
  // Period captured at start; only needed when expiry re-arms the timer.
  logic [SEC_W-1:0] reload;
  logic [SEC_W-1:0] reload_nx;
`endif

  assign wrap = (prescaler == PRE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      prescaler <= '0;
      remaining <= '0;
`ifdef SEC_TIMER_AUTORELOAD_EN
      reload    <= '0;
`endif
    end else begin
      state     <= state_nx;
      prescaler <= prescaler_nx;
      remaining <= remaining_nx;
`ifdef SEC_TIMER_AUTORELOAD_EN
      reload    <= reload_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    prescaler_nx = prescaler;
    remaining_nx = remaining;
`ifdef SEC_TIMER_AUTORELOAD_EN
    reload_nx    = reload;
`endif

    if (stop) begin
      state_nx     = ST_IDLE;
      prescaler_nx = '0;
    end else if (start) begin
`ifdef SEC_TIMER_AUTORELOAD_EN
      reload_nx    = load_val;
`endif
      prescaler_nx = '0;
      if (load_val != '0) begin
        remaining_nx = load_val;
        state_nx     = ST_RUN;
      end else begin
        remaining_nx = '0;
        state_nx     = ST_EXPIRE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          prescaler_nx = '0;
        end
        ST_RUN: begin
          if (wrap) begin
            prescaler_nx = '0;
            if (remaining != '0)
              remaining_nx = remaining - SEC_ONE;
            // Reaching zero wins over a simultaneous pause request.
            if (remaining <= SEC_ONE)
              state_nx = ST_EXPIRE;
            else if (pause)
              state_nx = ST_PAUSE;
          end else if (pause) begin
            state_nx = ST_PAUSE;
          end else begin
            prescaler_nx = prescaler + PRE_ONE;
          end
        end
        ST_PAUSE: begin
          if (pause)
            state_nx = ST_RUN;
        end
        ST_EXPIRE: begin
`ifdef SEC_TIMER_AUTORELOAD_EN
          if (reload != '0) begin
            remaining_nx = reload;
            prescaler_nx = '0;
            state_nx     = ST_RUN;
          end else begin
            state_nx = ST_IDLE;
          end
`else
          state_nx = ST_IDLE;
`endif
        end
        default: begin
          state_nx     = ST_IDLE;
          prescaler_nx = '0;
        end
      endcase
    end
  end

  assign tick    = (state == ST_RUN) && wrap;
  assign running = (state == ST_RUN);
  assign paused  = (state == ST_PAUSE);
  assign done    = (state == ST_EXPIRE);

endmodule
`default_nettype wire

// File: tb/tb_sec_timer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sec_timer_ctrl : directed + random bench against an elapsed-time model |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sec_timer_ctrl;

  localparam int DIV   = 10;
  localparam int SEC_W = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             pause;
  logic [SEC_W-1:0] load_val;
  logic [SEC_W-1:0] remaining;
  logic             tick;
  logic             running;
  logic             paused;
  logic             done;

  sec_timer_ctrl #(.DIV(DIV), .SEC_W(SEC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .load_val  (load_val),
    .remaining (remaining),
    .tick      (tick),
    .running   (running),
    .paused    (paused),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_vec     = 0;
  int n_err     = 0;
  int edge_no   = 0;
  int done_edge = -1;
  int done_q[$];
  int e0;

  // Model: seconds left = load - (counted cycles / DIV).
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int m_state, m_load, m_active, m_rem, m_reload;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_load   = 0;
    m_active = 0;
    m_rem    = 0;
    m_reload = 0;
  endtask

  task automatic model_edge(input logic st, input logic sp, input logic ps, input int ld);
    bit at_wrap;
    if (sp) begin
      m_state = M_IDLE;
    end else if (st) begin
      m_reload = ld;
      if (ld != 0) begin
        m_load = ld; m_active = 0; m_rem = ld; m_state = M_RUN;
      end else begin
        m_rem = 0; m_state = M_EXP;
      end
    end else begin
      case (m_state)
        M_RUN: begin
          at_wrap = ((m_active % DIV) == DIV - 1);
          if (at_wrap || !ps) m_active++;
          m_rem = m_load - m_active / DIV;
          if (m_rem == 0)  m_state = M_EXP;
          else if (ps)     m_state = M_PAUSE;
        end
        M_PAUSE: if (ps) m_state = M_RUN;
        M_EXP: begin
`ifdef SEC_TIMER_AUTORELOAD_EN
          if (m_reload != 0) begin
            m_load = m_reload; m_active = 0; m_rem = m_reload; m_state = M_RUN;
          end else begin
            m_state = M_IDLE;
          end
`else
          m_state = M_IDLE;
`endif
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check_eq("remaining", 32'(remaining), 32'(m_rem));
    check_eq("running",   32'(running),   32'(m_state == M_RUN));
    check_eq("paused",    32'(paused),    32'(m_state == M_PAUSE));
    check_eq("done",      32'(done),      32'(m_state == M_EXP));
    check_eq("tick",      32'(tick),      32'(m_state == M_RUN && (m_active % DIV) == DIV - 1));
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 ns later.
  task automatic cycle(input logic st, input logic sp, input logic ps, input logic [SEC_W-1:0] ld);
    start = st; stop = sp; pause = ps; load_val = ld;
    @(posedge clk);
    edge_no++;
    model_edge(st, sp, ps, int'(ld));
    #1;
    check_outputs();
    if (done) begin
      done_edge = edge_no;
      done_q.push_back(edge_no);
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cycle(1'b0, 1'b0, 1'b0, SEC_W'($urandom_range(0, 4095)));
  endtask

  task automatic async_reset_mid();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_remaining", 32'(remaining), 32'd0);
    check_eq("arst_running",   32'(running),   32'd0);
    check_eq("arst_tick",      32'(tick),      32'd0);
    check_eq("arst_paused",    32'(paused),    32'd0);
    check_eq("arst_done",      32'(done),      32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; load_val = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    idle(3);

    // Basic countdown of 3 s.
    cycle(1'b1, 1'b0, 1'b0, 12'd3); e0 = edge_no; done_edge = -1;
    idle(35);
    check_eq("basic_done_edge", 32'(done_edge - e0), 32'd30);

    // Pause at E15, resume at E115.
    cycle(1'b1, 1'b0, 1'b0, 12'd3); e0 = edge_no; done_edge = -1;
    idle(14);
    cycle(1'b0, 1'b0, 1'b1, 12'd0);
    check_eq("pause_rem", 32'(remaining), 32'd2);
    check_eq("pause_flag", 32'(paused), 32'd1);
    idle(99);
    cycle(1'b0, 1'b0, 1'b1, 12'd0);
    idle(25);
    check_eq("pause_done_edge", 32'(done_edge - e0), 32'd131);

    // Zero load expires immediately.
    cycle(1'b1, 1'b0, 1'b0, 12'd0);
    check_eq("zero_done", 32'(done), 32'd1);
    idle(1);
    check_eq("zero_done_end", 32'(done), 32'd0);

    // Stop at E25 freezes remaining, then restart with 1 s.
    cycle(1'b1, 1'b0, 1'b0, 12'd5); e0 = edge_no;
    idle(24);
    cycle(1'b0, 1'b1, 1'b0, 12'd0);
    check_eq("stop_rem", 32'(remaining), 32'd3);
    done_edge = -1;
    idle(100);
    check_eq("stop_no_done", 32'(done_edge), 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 1'b0, 12'd1); e0 = edge_no;
    idle(12);
    check_eq("restart_done_edge", 32'(done_edge - e0), 32'd10);

    // Pause on the final wrap edge: expiry wins.
    cycle(1'b1, 1'b0, 1'b0, 12'd3);
    idle(29);
    cycle(1'b0, 1'b0, 1'b1, 12'd0);
    check_eq("collide_done", 32'(done), 32'd1);
    check_eq("collide_paused", 32'(paused), 32'd0);
    idle(2);

    // Start and stop together -> IDLE.
    cycle(1'b1, 1'b1, 1'b0, 12'd4);
    check_eq("startstop_running", 32'(running), 32'd0);

    // Async reset mid-run.
    cycle(1'b1, 1'b0, 1'b0, 12'd7);
    idle(13);
    async_reset_mid();
    idle(3);

`ifdef SEC_TIMER_AUTORELOAD_EN
    cycle(1'b1, 1'b0, 1'b0, 12'd2); e0 = edge_no;
    done_q.delete();
    idle(70);
    check_eq("ar_count_ge3", 32'(done_q.size() >= 3), 32'd1);
    if (done_q.size() >= 3) begin
      check_eq("ar_done0", 32'(done_q[0] - e0), 32'd20);
      check_eq("ar_done1", 32'(done_q[1] - e0), 32'd41);
      check_eq("ar_done2", 32'(done_q[2] - e0), 32'd62);
    end
    cycle(1'b0, 1'b1, 1'b0, 12'd0);
    done_q.delete();
    idle(50);
    check_eq("ar_stop_no_done", 32'(done_q.size()), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic             st, sp, ps;
      logic [SEC_W-1:0] ld;
      st = ($urandom_range(0, 59) == 0);
      sp = ($urandom_range(0, 149) == 0);
      ps = ($urandom_range(0, 24) == 0);
      ld = ($urandom_range(0, 9) == 0) ? SEC_W'($urandom_range(0, 4095))
                                       : SEC_W'($urandom_range(0, 4));
      cycle(st, sp, ps, ld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sec_timer_ctrl.md
# sec_timer_ctrl

Countdown-timer controller that owns and sequences a 1-second prescaler (default 100 MHz -> 1 Hz) and the seconds counter it drives. Loads a seconds value on `start`, counts down one second per prescaler wrap, and supports pause/resume and stop. It pulses `done` at zero. Sits between the user-input debouncers and the display/alarm logic.

## Interface
- `DIV`, 100000000: clock cycles per second tick; legal range DIV >= 2.
- `SEC_W`, 12: width of the load value and the seconds counter.
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle pulse; loads `load_val` and (re)starts counting.
- `stop` input 1: one-cycle pulse; aborts counting and returns to IDLE.
- `pause` input 1: one-cycle pulse; toggles RUN <-> PAUSE.
- `load_val` input SEC_W: seconds to count; sampled only on the edge where `start` is accepted.
- `remaining` output SEC_W: current seconds left (registered).
- `tick` output 1: high for one cycle on each prescaler wrap while in RUN.
- `running` output 1: high in state RUN.
- `paused` output 1: high in state PAUSE.
- `done` output 1: high for exactly one cycle in state EXPIRE.

## Operation
- Prescaler width: $clog2(DIV). Counts 0..DIV-1, then wraps.
- `tick` = (state==RUN) && (prescaler==DIV-1), decoded combinationally from registers.
- State machine:
  - IDLE: prescaler held at 0; `remaining` holds its value. On `start` with `load_val` != 0: `remaining` <= `load_val`, reload register <= `load_val`, prescaler <= 0, go to RUN. On `start` with `load_val` == 0: `remaining` <= 0, go to EXPIRE.
  - RUN: prescaler increments each edge. On a wrap edge (prescaler==DIV-1): prescaler <= 0 and `remaining` decrements. If `remaining` is 1 at that edge, it becomes 0 and the next state is EXPIRE.
  - PAUSE: prescaler and `remaining` are frozen.
  - EXPIRE: lasts one cycle (`done`=1), then goes to IDLE.
- Input priority per edge: `reset` > `stop` > `start` > expiry > `pause` > plain tick.
  - `stop` in any state: go to IDLE, prescaler <= 0, `remaining` frozen, no `done`.
  - `start` in RUN, PAUSE or EXPIRE: full restart, same as `start` from IDLE.
  - `pause` on a wrap edge: the decrement is applied and the state goes to PAUSE. If that decrement reaches 0, the state goes to EXPIRE instead (expiry beats pause).
  - `pause` edges do not advance the prescaler: neither RUN->PAUSE nor PAUSE->RUN.
  - `pause` in IDLE or EXPIRE is ignored.
- Arithmetic is unsigned. `remaining` never decrements below 0 and never wraps.

## Timing
- Reset values: state IDLE, prescaler 0, reload register 0, `remaining` 0, `tick` 0, `running` 0, `paused` 0, `done` 0.
- Reset asserted mid-operation forces all of the above immediately, without waiting for an edge.
- Start is accepted at edge E0. `running`=1 from E0.
- First `tick` is in the cycle after edge E0+DIV-1. The first decrement happens at E0+DIV.
- For load N: `done` is high in the cycle after edge E0+N·DIV, and `running`=0 from that same edge.
- Every edge in PAUSE, plus the pause and resume edges themselves, delays expiry by one cycle.

## Configuration
- `SEC_TIMER_AUTORELOAD_EN` defined:
  - EXPIRE still pulses `done` for one cycle.
  - On exit from EXPIRE: `remaining` <= reload register, prescaler <= 0, go to RUN (periodic mode).
  - A reload value of 0 goes to IDLE.
- Not defined: EXPIRE always goes to IDLE. The reload register is used only for loading.

## Test plan
(All scenarios use DIV=10, SEC_W=12.)
- Basic countdown: `load_val`=3, `start` at edge E0.
  - `tick` high after E9, E19 and E29.
  - `remaining` reads 3/2/1/0 from E0/E10/E20/E30.
  - `done` high one cycle after E30; `running` falls at E30.
- Pause/resume: `load_val`=3, `start` at E0, `pause` at E15, `pause` at E115.
  - `paused`=1 over E15..E114.
  - `remaining` stays 2 throughout the pause.
  - `done` occurs after E131, exactly 101 cycles later than the basic case.
- Zero load: `load_val`=0 with `start`.
  - `done` high for one cycle after the start edge.
  - `running` never goes high; `tick` never fires.
- Stop and restart: `load_val`=5, `stop` at E25.
  - IDLE from E25 with `remaining`=3 frozen; no `done` and no `tick` for 100 cycles.
  - `start` with `load_val`=1 then gives `done` 10 cycles later.
- Reset and edge collisions:
  - Async `reset` mid-RUN clears all outputs before the next clock edge.
  - `pause` on the E29 wrap with `remaining`=1 leads to EXPIRE, not PAUSE.
  - `start` and `stop` asserted together lead to IDLE.
- Auto-reload (macro defined): `load_val`=2.
  - `done` pulses after E20, E41 and E62; `running` drops only during the EXPIRE cycles.
  - `stop` halts the sequence.
